// File: rtl/branch_predictor.sv
// IF-stage branch target prediction with 2-bit counters,
// ID-stage mispredict detection, redirect and table training.
module branch_predictor #(
  parameter int          IDX_W    = 4,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] IF_pc_i,
  output logic        IF_pred_taken_o,
  output logic [31:0] IF_pred_pc_o,
  input  logic [31:0] ID_pc_i,
  input  logic        ID_pred_taken_i,
  input  logic [31:0] ID_pred_pc_i,
  input  logic        ID_Branch_i,
  input  logic        ID_branch_ctr_i,
  input  logic [31:0] ID_branch_pc_i,
  input  logic        ID_stall_i,
  output logic        ID_flush_o,
  output logic [31:0] ID_redirect_pc_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispredict_cnt_o
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic              r_valid [N];
  logic [TAG_W-1:0]  r_tag   [N];
  logic [1:0]        r_cnt   [N];
  logic [31:0]       r_tgt   [N];
  logic [31:0]       r_branch_cnt;
  logic [31:0]       r_mis_cnt;

  logic [IDX_W-1:0]  w_if_idx;
  logic [TAG_W-1:0]  w_if_tag;
  logic              w_if_hit;
  logic [IDX_W-1:0]  w_id_idx;
  logic [TAG_W-1:0]  w_id_tag;
  logic              w_id_hit;
  logic              w_tgt_diff;
  logic              w_mis;
  logic              w_train;
  logic              w_alloc;
  logic              w_inc;
  logic              w_dec;
  logic              w_inval;

  assign w_if_idx = IF_pc_i[IDX_W+1:2];
  assign w_if_tag = IF_pc_i[31:IDX_W+2];
  assign w_if_hit = r_valid[w_if_idx] &&
                    (r_tag[w_if_idx] == w_if_tag);

  // Table read sees pre-update contents; no bypass from ID.
  assign IF_pred_taken_o = w_if_hit & r_cnt[w_if_idx][1];
  assign IF_pred_pc_o    = IF_pred_taken_o ?
                           r_tgt[w_if_idx] :
                           IF_pc_i + 32'd4;

  assign w_tgt_diff = ID_pred_pc_i != ID_branch_pc_i;
  assign w_mis = ID_Branch_i ?
    ((ID_pred_taken_i ^ ID_branch_ctr_i) |
     (ID_pred_taken_i & ID_branch_ctr_i & w_tgt_diff)) :
    ID_pred_taken_i;

  assign ID_flush_o       = w_mis & ~ID_stall_i;
  assign ID_redirect_pc_o = (ID_Branch_i & ID_branch_ctr_i) ?
                            ID_branch_pc_i :
                            ID_pc_i + 32'd4;

  assign w_id_idx = ID_pc_i[IDX_W+1:2];
  assign w_id_tag = ID_pc_i[31:IDX_W+2];
  assign w_id_hit = r_valid[w_id_idx] &&
                    (r_tag[w_id_idx] == w_id_tag);

  assign w_train = ID_Branch_i & ~ID_stall_i;
  assign w_alloc = w_train & ID_branch_ctr_i & ~w_id_hit;
  assign w_inc   = w_train & ID_branch_ctr_i & w_id_hit;
  assign w_dec   = w_train & ~ID_branch_ctr_i & w_id_hit;
  assign w_inval = ~ID_Branch_i & ~ID_stall_i & w_id_hit;

  assign branch_cnt_o     = r_branch_cnt;
  assign mispredict_cnt_o = r_mis_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < N; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_cnt[i]   <= CNT_INIT;
        r_tgt[i]   <= '0;
      end
      r_branch_cnt <= '0;
      r_mis_cnt    <= '0;
    end else begin
      unique case (1'b1)
        w_alloc: begin
          r_valid[w_id_idx] <= 1'b1;
          r_tag[w_id_idx]   <= w_id_tag;
          r_cnt[w_id_idx]   <= 2'b10;
          r_tgt[w_id_idx]   <= ID_branch_pc_i;
        end
        w_inc: begin
          if (r_cnt[w_id_idx] != 2'b11)
            r_cnt[w_id_idx] <= r_cnt[w_id_idx] + 2'd1;
          r_tgt[w_id_idx] <= ID_branch_pc_i;
        end
        w_dec: begin
          if (r_cnt[w_id_idx] != 2'b00)
            r_cnt[w_id_idx] <= r_cnt[w_id_idx] - 2'd1;
        end
        w_inval: r_valid[w_id_idx] <= 1'b0;
        default: ;
      endcase
      if (w_train)
        r_branch_cnt <= r_branch_cnt + 32'd1;
      if (ID_flush_o)
        r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus random checks of branch_predictor against
// a behavioural table model keyed by full word address.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] id_pc = '0;
  logic        id_pt = 1'b0;
  logic [31:0] id_ppc = '0;
  logic        id_br = 1'b0;
  logic        id_ctr = 1'b0;
  logic [31:0] id_bpc = '0;
  logic        id_st = 1'b0;

  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        flush;
  logic [31:0] redirect;
  logic [31:0] bcnt;
  logic [31:0] mcnt;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .IF_pc_i          (if_pc),
    .IF_pred_taken_o  (pred_taken),
    .IF_pred_pc_o     (pred_pc),
    .ID_pc_i          (id_pc),
    .ID_pred_taken_i  (id_pt),
    .ID_pred_pc_i     (id_ppc),
    .ID_Branch_i      (id_br),
    .ID_branch_ctr_i  (id_ctr),
    .ID_branch_pc_i   (id_bpc),
    .ID_stall_i       (id_st),
    .ID_flush_o       (flush),
    .ID_redirect_pc_o (redirect),
    .branch_cnt_o     (bcnt),
    .mispredict_cnt_o (mcnt)
  );

  int tests = 0;
  int fails = 0;

  // Model: entry holds the whole word address it was trained on.
  bit          m_valid [16];
  logic [31:0] m_key   [16];
  int          m_cnt   [16];
  logic [31:0] m_tgt   [16];
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_key[slot(pc)] == (pc >> 2));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mis();
    if (id_br)
      return (id_pt != id_ctr) ||
             (id_pt && id_ctr && (id_ppc != id_bpc));
    return id_pt;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_key[i]   = '0;
      m_cnt[i]   = 1;
      m_tgt[i]   = '0;
    end
    m_bc = '0;
    m_mc = '0;
  endtask

  task automatic m_update();
    int s;
    bit h;
    bit mis;
    s   = slot(id_pc);
    h   = m_hit(id_pc);
    mis = m_mis();
    if (!id_st) begin
      if (id_br) begin
        m_bc = m_bc + 1;
        if (id_ctr && h) begin
          m_cnt[s] = (m_cnt[s] + 1 > 3) ? 3 : m_cnt[s] + 1;
          m_tgt[s] = id_bpc;
        end else if (id_ctr) begin
          m_valid[s] = 1'b1;
          m_key[s]   = id_pc >> 2;
          m_cnt[s]   = 2;
          m_tgt[s]   = id_bpc;
        end else if (h) begin
          m_cnt[s] = (m_cnt[s] - 1 < 0) ? 0 : m_cnt[s] - 1;
        end
      end else if (h) begin
        m_valid[s] = 1'b0;
      end
      if (mis) m_mc = m_mc + 1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("if_taken", 32'(pred_taken), 32'(m_taken(if_pc)));
    chk("if_pc", pred_pc, m_next(if_pc));
    chk("flush", 32'(flush), 32'(m_mis() && !id_st));
    chk("redirect", redirect,
        (id_br && id_ctr) ? id_bpc : id_pc + 32'd4);
    chk("branch_cnt", bcnt, m_bc);
    chk("mis_cnt", mcnt, m_mc);
  endtask

  task automatic drive(input logic [31:0] ifpc,
                       input logic [31:0] idpc,
                       input logic        pt,
                       input logic [31:0] ppc,
                       input logic        br,
                       input logic        ctr,
                       input logic [31:0] bpc,
                       input logic        st);
    if_pc  = ifpc;
    id_pc  = idpc;
    id_pt  = pt;
    id_ppc = ppc;
    id_br  = br;
    id_ctr = ctr;
    id_bpc = bpc;
    id_st  = st;
    #1;
    check_all();
  endtask

  task automatic idle(input logic [31:0] ifpc);
    drive(ifpc, 32'h3000, 1'b0, 32'h3004,
          1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rpc();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0: t = 32'h0;
      1: t = 32'h1;
      2: t = 32'h2;
      default: t = 32'h3FF_FFFF;
    endcase
    return (t << 6) | (32'($urandom_range(0, 15)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  task automatic rand_step();
    logic [31:0] ip;
    logic [31:0] dp;
    logic [31:0] bp;
    logic [31:0] pp;
    logic        b;
    logic        c;
    logic        p;
    ip = rpc();
    dp = rpc();
    b  = ($urandom_range(0, 3) != 0);
    c  = b & 1'($urandom);
    bp = ($urandom_range(0, 1) == 1) ?
         rpc() & 32'hFFFF_FFFC : $urandom;
    p  = ($urandom_range(0, 1) == 1) ?
         m_taken(dp) : 1'($urandom);
    case ($urandom_range(0, 2))
      0: pp = m_next(dp);
      1: pp = bp;
      default: pp = $urandom;
    endcase
    if (!p) pp = dp + 32'd4;
    drive(ip, dp, p, pp, b, c, bp,
          $urandom_range(0, 4) == 0);
    tick();
  endtask

  logic [31:0] sv_bc;
  logic [31:0] sv_mc;

  initial begin
    m_reset();
    idle(32'h100);
    chk("rst_taken", 32'(pred_taken), 32'h0);
    chk("rst_pc", pred_pc, 32'h104);
    chk("rst_bcnt", bcnt, 32'h0);
    chk("rst_mcnt", mcnt, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    drive(32'h100, 32'h100, 1'b0, 32'h104,
          1'b1, 1'b1, 32'h80, 1'b0);
    chk("d1_flush", 32'(flush), 32'h1);
    chk("d1_redir", redirect, 32'h80);
    tick();
    idle(32'h100);
    chk("d1_mcnt", mcnt, 32'h1);
    chk("d1_taken", 32'(pred_taken), 32'h1);
    chk("d1_pc", pred_pc, 32'h80);

    for (int k = 0; k < 3; k++) begin
      drive(32'h100, 32'h100, 1'b1, 32'h80,
            1'b1, 1'b1, 32'h80, 1'b0);
      chk("sat_noflush", 32'(flush), 32'h0);
      tick();
    end
    drive(32'h100, 32'h100, 1'b1, 32'h80,
          1'b1, 1'b0, 32'h0, 1'b0);
    chk("nt1_flush", 32'(flush), 32'h1);
    chk("nt1_redir", redirect, 32'h104);
    tick();
    drive(32'h100, 32'h100, 1'b1, 32'h80,
          1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    idle(32'h100);
    chk("nt2_taken", 32'(pred_taken), 32'h0);
    chk("nt2_pc", pred_pc, 32'h104);

    drive(32'h140, 32'h140, 1'b0, 32'h144,
          1'b1, 1'b1, 32'h200, 1'b0);
    chk("alias_flush", 32'(flush), 32'h1);
    tick();
    idle(32'h100);
    chk("alias_old_pc", pred_pc, 32'h104);
    idle(32'h140);
    chk("alias_new_pc", pred_pc, 32'h200);

    sv_bc = bcnt;
    sv_mc = mcnt;
    drive(32'h184, 32'h184, 1'b0, 32'h188,
          1'b1, 1'b1, 32'h300, 1'b1);
    chk("stall_flush", 32'(flush), 32'h0);
    tick();
    idle(32'h184);
    chk("stall_taken", 32'(pred_taken), 32'h0);
    chk("stall_bcnt", bcnt, sv_bc);
    chk("stall_mcnt", mcnt, sv_mc);
    drive(32'h184, 32'h184, 1'b0, 32'h188,
          1'b1, 1'b1, 32'h300, 1'b0);
    chk("unstall_flush", 32'(flush), 32'h1);
    tick();
    idle(32'h184);
    chk("unstall_pc", pred_pc, 32'h300);
    chk("unstall_bcnt", bcnt, sv_bc + 32'd1);
    chk("unstall_mcnt", mcnt, sv_mc + 32'd1);

    for (int n = 0; n < 400; n++) rand_step();

    for (int k = 0; k < 2; k++) begin
      drive(32'h140, 32'h140, 1'b0, 32'h144,
            1'b1, 1'b1, 32'h200, 1'b0);
      tick();
    end
    idle(32'h140);
    chk("pre_rst_pc", pred_pc, 32'h200);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_taken", 32'(pred_taken), 32'h0);
    chk("arst_pc", pred_pc, 32'h144);
    chk("arst_bcnt", bcnt, 32'h0);
    chk("arst_mcnt", mcnt, 32'h0);
    m_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 50; n++) rand_step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
